// File: rtl/mem_pkg.sv
// Shared encodings for the memory-access stage: access sizes, FSM states and
// big-endian byte-enable patterns.
package mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam logic [3:0] BE_BYTE0 = 4'b1000;
   localparam logic [3:0] BE_HALF0 = 4'b1100;
   localparam logic [3:0] BE_HALF2 = 4'b0011;
   localparam logic [3:0] BE_WORD  = 4'b1111;

   localparam int CNT_W = 8;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } state_e;

endpackage

// File: rtl/load_store_align.sv
// Combinational lane steering: byte enables and replicated store data for a
// request, lane extraction and extension for load data, and alignment check.
module load_store_align
   import mem_pkg::*;
(
   input  logic [1:0]  off_i,
   input  logic [1:0]  size_i,
   input  logic        signed_i,
   input  logic [31:0] sdata_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] ldata_o,
   output logic        misaligned_o
);

   logic [7:0]  lane8;
   logic [15:0] lane16;

   always_comb begin
      be_o         = BE_WORD;
      wdata_o      = sdata_i;
      ldata_o      = rdata_i;
      misaligned_o = 1'b0;
      lane8        = rdata_i[31:24];
      lane16       = rdata_i[31:16];
      case (size_i)
         SZ_BYTE: begin
            be_o    = BE_BYTE0 >> off_i;
            wdata_o = {4{sdata_i[7:0]}};
            // Big-endian: offset 0 is the most significant byte
            case (off_i)
               2'd0:    lane8 = rdata_i[31:24];
               2'd1:    lane8 = rdata_i[23:16];
               2'd2:    lane8 = rdata_i[15:8];
               default: lane8 = rdata_i[7:0];
            endcase
            ldata_o = {{24{signed_i & lane8[7]}}, lane8};
         end
         SZ_HALF: begin
            be_o         = off_i[1] ? BE_HALF2 : BE_HALF0;
            wdata_o      = {2{sdata_i[15:0]}};
            lane16       = off_i[1] ? rdata_i[15:0] : rdata_i[31:16];
            ldata_o      = {{16{signed_i & lane16[15]}}, lane16};
            misaligned_o = off_i[0];
         end
         default: begin
            misaligned_o = (off_i != 2'b00);
         end
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers EX results, runs load/store through a
// req/ack handshake with timeout, stalls upstream while a transaction is open.
module mem_stage
   import mem_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ex_valid,
   input  logic        flush,
   input  logic [31:0] ex_alu_result,
   input  logic [31:0] ex_store_data,
   input  logic [4:0]  ex_rd,
   input  logic        ex_load,
   input  logic        ex_store,
   input  logic        ex_rf_enable,
   input  logic        ex_signed,
   input  logic [1:0]  ex_size,
   output logic        mem_stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        wb_valid,
   output logic        wb_rf_enable,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        align_err,
   output logic        bus_err
);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [29:0]        addr_q, addr_d;
   logic [1:0]         off_q, off_d;
   logic [1:0]         size_q, size_d;
   logic               signed_q, signed_d;
   logic               we_q, we_d;
   logic [3:0]         be_q, be_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [4:0]         rd_q, rd_d;
   logic               rfen_q, rfen_d;
   logic               wb_valid_q, wb_valid_d;
   logic               wb_rf_q, wb_rf_d;
   logic [4:0]         wb_rd_q, wb_rd_d;
   logic [31:0]        wb_data_q, wb_data_d;
   logic               align_err_q, align_err_d;
   logic               bus_err_q, bus_err_d;

   logic               idle;
   logic [1:0]         al_off, al_size;
   logic               al_signed, al_misaligned;
   logic [3:0]         al_be;
   logic [31:0]        al_wdata, al_ldata;

   assign idle = (state_q == ST_IDLE);

   // One aligner serves both phases: EX attributes in IDLE, latched ones in ACCESS
   assign al_off    = idle ? ex_alu_result[1:0] : off_q;
   assign al_size   = idle ? ex_size            : size_q;
   assign al_signed = idle ? ex_signed          : signed_q;

   load_store_align u_align (
      .off_i        (al_off),
      .size_i       (al_size),
      .signed_i     (al_signed),
      .sdata_i      (ex_store_data),
      .rdata_i      (mem_rdata),
      .be_o         (al_be),
      .wdata_o      (al_wdata),
      .ldata_o      (al_ldata),
      .misaligned_o (al_misaligned)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      off_d       = off_q;
      size_d      = size_q;
      signed_d    = signed_q;
      we_d        = we_q;
      be_d        = be_q;
      wdata_d     = wdata_q;
      rd_d        = rd_q;
      rfen_d      = rfen_q;
      wb_valid_d  = 1'b0;
      wb_rf_d     = 1'b0;
      wb_rd_d     = wb_rd_q;
      wb_data_d   = wb_data_q;
      align_err_d = 1'b0;
      bus_err_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (ex_valid && !flush) begin
               wb_rd_d = ex_rd;
               if (!(ex_load || ex_store)) begin
                  wb_valid_d = 1'b1;
                  wb_data_d  = ex_alu_result;
                  wb_rf_d    = ex_rf_enable && (ex_rd != 5'd0);
               end else if (al_misaligned) begin
                  wb_valid_d  = 1'b1;
                  wb_data_d   = ex_alu_result;
                  align_err_d = 1'b1;
               end else begin
                  state_d  = ST_ACCESS;
                  cnt_d    = '0;
                  addr_d   = ex_alu_result[31:2];
                  off_d    = ex_alu_result[1:0];
                  size_d   = ex_size;
                  signed_d = ex_signed;
                  we_d     = ex_store;
                  be_d     = al_be;
                  wdata_d  = al_wdata;
                  rd_d     = ex_rd;
                  rfen_d   = ex_rf_enable && (ex_rd != 5'd0);
               end
            end
         end
         ST_ACCESS: begin
            // Ack takes priority over an expiring timeout on the same edge
            if (mem_ack) begin
               state_d    = ST_IDLE;
               wb_valid_d = 1'b1;
               wb_rd_d    = rd_q;
               if (we_q) begin
                  wb_data_d = {addr_q, off_q};
               end else begin
                  wb_data_d = al_ldata;
                  wb_rf_d   = rfen_q;
               end
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d    = ST_IDLE;
               wb_valid_d = 1'b1;
               wb_rd_d    = rd_q;
               wb_data_d  = '0;
               bus_err_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         off_q       <= '0;
         size_q      <= '0;
         signed_q    <= 1'b0;
         we_q        <= 1'b0;
         be_q        <= '0;
         wdata_q     <= '0;
         rd_q        <= '0;
         rfen_q      <= 1'b0;
         wb_valid_q  <= 1'b0;
         wb_rf_q     <= 1'b0;
         wb_rd_q     <= '0;
         wb_data_q   <= '0;
         align_err_q <= 1'b0;
         bus_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         off_q       <= off_d;
         size_q      <= size_d;
         signed_q    <= signed_d;
         we_q        <= we_d;
         be_q        <= be_d;
         wdata_q     <= wdata_d;
         rd_q        <= rd_d;
         rfen_q      <= rfen_d;
         wb_valid_q  <= wb_valid_d;
         wb_rf_q     <= wb_rf_d;
         wb_rd_q     <= wb_rd_d;
         wb_data_q   <= wb_data_d;
         align_err_q <= align_err_d;
         bus_err_q   <= bus_err_d;
      end
   end

   assign mem_stall    = (state_q == ST_ACCESS);
   assign mem_req      = (state_q == ST_ACCESS);
   assign mem_we       = we_q;
   assign mem_addr     = {addr_q, 2'b00};
   assign mem_wdata    = wdata_q;
   assign mem_be       = be_q;
   assign wb_valid     = wb_valid_q;
   assign wb_rf_enable = wb_rf_q;
   assign wb_rd        = wb_rd_q;
   assign wb_data      = wb_data_q;
   assign align_err    = align_err_q;
   assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: table of single-cycle IDLE vectors plus
// hand-written load/store, timeout and reset sequences.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        ex_valid, flush;
   logic [31:0] ex_alu_result, ex_store_data;
   logic [4:0]  ex_rd;
   logic        ex_load, ex_store, ex_rf_enable, ex_signed;
   logic [1:0]  ex_size;
   logic        mem_stall, mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        wb_valid, wb_rf_enable;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        align_err, bus_err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mem_stage #(.TIMEOUT(16)) dut (
      .clk(clk), .reset(reset), .ex_valid(ex_valid), .flush(flush),
      .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
      .ex_load(ex_load), .ex_store(ex_store), .ex_rf_enable(ex_rf_enable),
      .ex_signed(ex_signed), .ex_size(ex_size), .mem_stall(mem_stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .wb_valid(wb_valid),
      .wb_rf_enable(wb_rf_enable), .wb_rd(wb_rd), .wb_data(wb_data),
      .align_err(align_err), .bus_err(bus_err)
   );

   typedef struct {
      logic        valid, flsh, ld, st, rfen, sgn;
      logic [1:0]  size;
      logic [31:0] alu;
      logic [4:0]  rd;
      logic        e_valid, e_rf, e_align;
      logic [31:0] e_data;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, fl, ld, st, rfen, sgn, input logic [1:0] sz,
                        input logic [31:0] alu, sd, input logic [4:0] rd);
      ex_valid = v; flush = fl; ex_load = ld; ex_store = st; ex_rf_enable = rfen;
      ex_signed = sgn; ex_size = sz; ex_alu_result = alu; ex_store_data = sd; ex_rd = rd;
   endtask

   task automatic idle_inputs();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
   endtask

   // Caller is at a negedge. Issues the op, acks after ack_after stalled
   // cycles (negative = never), returns number of stalled cycles observed.
   task automatic mem_op(input string nm, input logic ld, st, sgn, input logic [1:0] sz,
                         input logic [31:0] addr, sd, input logic [4:0] rd,
                         input int ack_after, input logic [31:0] rdata,
                         input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                         output int stall_cnt);
      drive(1'b1, 1'b0, ld, st, 1'b1, sgn, sz, addr, sd, rd);
      stall_cnt = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (!mem_stall) break;
         stall_cnt++;
         if (c == 0) begin
            chk({nm, "_req"}, {31'd0, mem_req}, 32'd1);
            chk({nm, "_we"}, {31'd0, mem_we}, {31'd0, st});
            chk({nm, "_be"}, {28'd0, mem_be}, {28'd0, exp_be});
            if (st) chk({nm, "_wdata"}, mem_wdata, exp_wdata);
         end
         chk({nm, "_addr_stable"}, mem_addr, {addr[31:2], 2'b00});
         // Upstream noise and flush must not disturb an open access
         drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 32'hFFFF_FFF0 + c, 32'h5A5A5A5A, 5'd9);
         mem_ack   = (c == ack_after);
         mem_rdata = (c == ack_after) ? rdata : 32'hDEAD_0000;
      end
      mem_ack = 1'b0;
      idle_inputs();
   endtask

   vec_t vecs[8];
   int   sc;

   initial begin
      reset = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
      idle_inputs();

      vecs[0] = '{1,0,0,0,1,0,2'b10,32'h12345678,5'd3, 1,1,0,32'h12345678};
      vecs[1] = '{1,0,0,0,1,0,2'b10,32'hDEADBEEF,5'd0, 1,0,0,32'hDEADBEEF};
      vecs[2] = '{1,0,0,0,0,0,2'b10,32'h0000_00A5,5'd5, 1,0,0,32'h0000_00A5};
      vecs[3] = '{1,1,0,0,1,0,2'b10,32'h7777_7777,5'd6, 0,0,0,32'h0};
      vecs[4] = '{1,0,1,0,1,0,2'b10,32'h0000_0003,5'd4, 1,0,1,32'h0000_0003};
      vecs[5] = '{1,0,0,1,1,0,2'b01,32'h0000_1001,5'd2, 1,0,1,32'h0000_1001};
      vecs[6] = '{0,0,0,0,1,0,2'b10,32'h1111_1111,5'd7, 0,0,0,32'h0};
      vecs[7] = '{1,0,1,0,1,1,2'b11,32'h0000_0002,5'd8, 1,0,1,32'h0000_0002};

      repeat (2) @(negedge clk);
      chk("rst_req",   {31'd0, mem_req},   32'd0);
      chk("rst_stall", {31'd0, mem_stall}, 32'd0);
      chk("rst_wbv",   {31'd0, wb_valid},  32'd0);
      chk("rst_data",  wb_data,            32'd0);
      chk("rst_be",    {28'd0, mem_be},    32'd0);
      reset = 1'b1;

      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         drive(vecs[i].valid, vecs[i].flsh, vecs[i].ld, vecs[i].st, vecs[i].rfen,
               vecs[i].sgn, vecs[i].size, vecs[i].alu, 32'h0, vecs[i].rd);
         @(negedge clk);
         chk($sformatf("v%0d_wbv", i),   {31'd0, wb_valid},     {31'd0, vecs[i].e_valid});
         chk($sformatf("v%0d_rf", i),    {31'd0, wb_rf_enable}, {31'd0, vecs[i].e_rf});
         chk($sformatf("v%0d_align", i), {31'd0, align_err},    {31'd0, vecs[i].e_align});
         chk($sformatf("v%0d_req", i),   {31'd0, mem_req},      32'd0);
         if (vecs[i].e_valid) begin
            chk($sformatf("v%0d_data", i), wb_data, vecs[i].e_data);
            chk($sformatf("v%0d_rd", i),   {27'd0, wb_rd}, {27'd0, vecs[i].rd});
         end
         idle_inputs();
         @(negedge clk);
         chk($sformatf("v%0d_pulse", i), {30'd0, wb_valid, align_err}, 32'd0);
      end

      // Signed byte load at 0x1001, ack after 3 wait cycles
      mem_op("lb", 1, 0, 1, 2'b00, 32'h0000_1001, 32'h0, 5'd7, 3, 32'h11F2_3344,
             4'b0100, 32'h0, sc);
      chk("lb_stall_cycles", sc, 32'd4);
      chk("lb_wbv",  {31'd0, wb_valid},     32'd1);
      chk("lb_data", wb_data,               32'hFFFF_FFF2);
      chk("lb_rf",   {31'd0, wb_rf_enable}, 32'd1);
      chk("lb_rd",   {27'd0, wb_rd},        32'd7);
      chk("lb_req",  {31'd0, mem_req},      32'd0);
      @(negedge clk);
      chk("lb_wbv_once", {31'd0, wb_valid}, 32'd0);

      // Unsigned half load at offset 0
      mem_op("lhu", 1, 0, 0, 2'b01, 32'h0000_3000, 32'h0, 5'd10, 1, 32'h8001_7FFF,
             4'b1100, 32'h0, sc);
      chk("lhu_stall_cycles", sc, 32'd2);
      chk("lhu_data", wb_data, 32'h0000_8001);

      // Half store at 0x2002, immediate ack
      @(negedge clk);
      mem_op("sh", 0, 1, 0, 2'b01, 32'h0000_2002, 32'h0000_ABCD, 5'd1, 0, 32'h0,
             4'b0011, 32'hABCD_ABCD, sc);
      chk("sh_stall_cycles", sc, 32'd1);
      chk("sh_wbv", {31'd0, wb_valid},     32'd1);
      chk("sh_rf",  {31'd0, wb_rf_enable}, 32'd0);

      // Ack arriving on the timeout edge wins
      @(negedge clk);
      mem_op("lwedge", 1, 0, 0, 2'b10, 32'h0000_0100, 32'h0, 5'd11, 15, 32'hCAFE_F00D,
             4'b1111, 32'h0, sc);
      chk("lwedge_stall_cycles", sc, 32'd16);
      chk("lwedge_data", wb_data, 32'hCAFE_F00D);
      chk("lwedge_rf",   {31'd0, wb_rf_enable}, 32'd1);
      chk("lwedge_buserr", {31'd0, bus_err}, 32'd0);

      // Word load never acknowledged
      @(negedge clk);
      mem_op("lwto", 1, 0, 0, 2'b10, 32'h0000_0040, 32'h0, 5'd12, -1, 32'h0,
             4'b1111, 32'h0, sc);
      chk("lwto_stall_cycles", sc, 32'd16);
      chk("lwto_buserr", {31'd0, bus_err},      32'd1);
      chk("lwto_wbv",    {31'd0, wb_valid},     32'd1);
      chk("lwto_rf",     {31'd0, wb_rf_enable}, 32'd0);
      chk("lwto_req",    {31'd0, mem_req},      32'd0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 32'h0BAD_CAFE, 32'h0, 5'd13);
      @(negedge clk);
      idle_inputs();
      chk("after_to_wbv",    {31'd0, wb_valid}, 32'd1);
      chk("after_to_data",   wb_data,           32'h0BAD_CAFE);
      chk("after_to_buserr", {31'd0, bus_err},  32'd0);

      // Reset in the middle of an access
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 32'h0000_0080, 32'h0, 5'd14);
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
      chk("pre_rst_req", {31'd0, mem_req}, 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_req",   {31'd0, mem_req},   32'd0);
      chk("mid_rst_stall", {31'd0, mem_stall}, 32'd0);
      chk("mid_rst_wbv",   {31'd0, wb_valid},  32'd0);
      @(negedge clk);
      reset = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 32'h0000_BEEF, 32'h0, 5'd15);
      @(negedge clk);
      idle_inputs();
      chk("post_rst_wbv",  {31'd0, wb_valid}, 32'd1);
      chk("post_rst_data", wb_data,           32'h0000_BEEF);
      chk("post_rst_rf",   {31'd0, wb_rf_enable}, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
